// File: rtl/alu_bist_pkg.sv
// Shared types for the ALU self-test: opcodes, FSM states, vector record and default table.
package alu_bist_pkg;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOr    = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluPassB = 4'b0111;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StDone
  } state_e;

  // exp is {Zero, BusW}
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctrl;
    logic [64:0] exp;
  } vec_t;

  localparam int unsigned NumDefaultVec = 18;

  localparam vec_t DefaultTable [NumDefaultVec] = '{
    '{64'h27,                  64'h987,                  AluAnd,   {1'b0, 64'h7}},
    '{64'hFFFF,                64'h0,                    AluAnd,   {1'b1, 64'h0}},
    '{64'hFF0A,                64'hFFFF,                 AluAnd,   {1'b0, 64'hFF0A}},
    '{64'hFFFF,                64'h1234,                 AluOr,    {1'b0, 64'hFFFF}},
    '{64'h12,                  64'h1200,                 AluOr,    {1'b0, 64'h1212}},
    '{64'h1,                   64'hF000,                 AluOr,    {1'b0, 64'hF001}},
    '{64'h27,                  64'h987,                  AluAdd,   {1'b0, 64'h9AE}},
    '{64'hFF00,                64'hFF,                   AluAdd,   {1'b0, 64'hFFFF}},
    '{64'h0,                   64'h0,                    AluAdd,   {1'b1, 64'h0}},
    '{64'h432,                 64'h432,                  AluSub,   {1'b1, 64'h0}},
    '{64'hFF00,                64'hFF,                   AluSub,   {1'b0, 64'hFE01}},
    '{64'h5,                   64'h4,                    AluSub,   {1'b0, 64'h1}},
    '{64'h4312,                64'h69,                   AluPassB, {1'b0, 64'h69}},
    '{64'h546,                 64'h0,                    AluPassB, {1'b1, 64'h0}},
    '{64'h8098,                64'h1234,                 AluPassB, {1'b0, 64'h1234}},
    '{64'hFFFF_FFFF_FFFF_FFE7, 64'h4,                    AluAdd,   {1'b0, 64'hFFFF_FFFF_FFFF_FFEB}},
    '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, AluAdd,   {1'b0, 64'hFFFF_FFFF_FFFF_FFF8}},
    '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, AluSub,   {1'b0, 64'h2}}
  };

  // Returned for indices past the table: trivially self-consistent AND 0,0.
  localparam vec_t IdleVec = '{64'h0, 64'h0, AluAnd, {1'b1, 64'h0}};

endpackage

// File: rtl/alu_bist_if.sv
// ALU operand/result bus between the self-test initiator (master) and the ALU (slave).
interface alu_bist_if;

  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusW;
  logic        Zero;

  modport master (
    output BusA,
    output BusB,
    output ALUCtrl,
    input  BusW,
    input  Zero
  );

  modport slave (
    input  BusA,
    input  BusB,
    input  ALUCtrl,
    output BusW,
    output Zero
  );

endinterface

// File: rtl/alu_bist_rom.sv
// Combinational test-vector lookup; swap the table here without touching the sequencer.
module alu_bist_rom
  import alu_bist_pkg::*;
(
  input  logic [7:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec = IdleVec;
    if (idx < 8'(NumDefaultVec)) begin
      vec = DefaultTable[idx[4:0]];
    end
  end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: drives table vectors, samples {Zero, BusW}, tallies results.
// Optional: define ALU_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VEC = 18,
  parameter int unsigned SETTLE  = 1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  alu_bist_if.master alu,
  output logic       Busy,
  output logic       Done,
  output logic       AllPass,
  output logic [7:0] PassCount,
  output logic [7:0] FailCount,
  output logic [7:0] FailIndex
);

  localparam int unsigned     CntW     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [7:0]      LastIdx  = 8'(NUM_VEC - 1);
  localparam logic [7:0]      NoFail   = 8'hFF;

  state_e          state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     bus_a_q, bus_a_d;
  logic [63:0]     bus_b_q, bus_b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      pass_q, pass_d;
  logic [7:0]      fail_q, fail_d;
  logic [7:0]      fail_idx_q, fail_idx_d;
  logic            match;
  logic            stop;
  vec_t            cur_vec;

  alu_bist_rom u_rom (
    .idx (idx_q),
    .vec (cur_vec)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bus_a_d    = bus_a_q;
    bus_b_d    = bus_b_q;
    ctrl_d     = ctrl_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    match      = ({alu.Zero, alu.BusW} == cur_vec.exp);
    stop       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          pass_d     = 8'd0;
          fail_d     = 8'd0;
          fail_idx_d = NoFail;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          idx_d      = 8'd0;
          state_d    = StDrive;
        end
      end
      StDrive: begin
        bus_a_d = cur_vec.a;
        bus_b_d = cur_vec.b;
        ctrl_d  = cur_vec.ctrl;
        cnt_d   = SettleLd;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q <= CntOne) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (match) begin
          pass_d = pass_q + 8'd1;
        end else begin
          fail_d = fail_q + 8'd1;
          if (fail_idx_q == NoFail) begin
            fail_idx_d = idx_q;
          end
        end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        stop = (idx_q == LastIdx) || !match;
`else
        stop = (idx_q == LastIdx);
`endif
        if (stop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      idx_q      <= 8'd0;
      cnt_q      <= '0;
      bus_a_q    <= 64'd0;
      bus_b_q    <= 64'd0;
      ctrl_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 8'd0;
      fail_q     <= 8'd0;
      fail_idx_q <= NoFail;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bus_a_q    <= bus_a_d;
      bus_b_q    <= bus_b_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign alu.BusA    = bus_a_q;
  assign alu.BusB    = bus_b_q;
  assign alu.ALUCtrl = ctrl_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign AllPass     = done_q && (fail_q == 8'd0);
  assign PassCount   = pass_q;
  assign FailCount   = fail_q;
  assign FailIndex   = fail_idx_q;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with injectable faults plus a cycle-level run model.
module tb_alu_bist;

  localparam int NV = 18;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic       AllPass;
  logic [7:0] PassCount;
  logic [7:0] FailCount;
  logic [7:0] FailIndex;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int fault_mode = 0;  // 0 good ALU, 1 SUB computes A+B, 2 Zero stuck at 0

  alu_bist_if alu_if ();

  alu_bist #(
    .NUM_VEC (18),
    .SETTLE  (1)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .alu       (alu_if),
    .Busy      (Busy),
    .Done      (Done),
    .AllPass   (AllPass),
    .PassCount (PassCount),
    .FailCount (FailCount),
    .FailIndex (FailIndex)
  );

  always #5 CLK = ~CLK;

  logic [63:0] tv_a [NV] = '{64'h27, 64'hFFFF, 64'hFF0A, 64'hFFFF, 64'h12, 64'h1, 64'h27,
                             64'hFF00, 64'h0, 64'h432, 64'hFF00, 64'h5, 64'h4312, 64'h546,
                             64'h8098, -64'h19, -64'h3, -64'h3};
  logic [63:0] tv_b [NV] = '{64'h987, 64'h0, 64'hFFFF, 64'h1234, 64'h1200, 64'hF000, 64'h987,
                             64'hFF, 64'h0, 64'h432, 64'hFF, 64'h4, 64'h69, 64'h0, 64'h1234,
                             64'h4, -64'h5, -64'h5};
  logic [3:0]  tv_op [NV] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h6, 4'h6,
                              4'h6, 4'h7, 4'h7, 4'h7, 4'h2, 4'h2, 4'h6};

  function automatic logic [63:0] ideal(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] op);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return b;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [64:0] faulty_alu(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op, input int f);
    logic [63:0] w;
    logic        z;
    w = (f == 1 && op == 4'h6) ? a + b : ideal(a, b, op);
    z = (f == 2) ? 1'b0 : (w == 64'h0);
    return {z, w};
  endfunction

  function automatic bit vec_passes(input int i, input int f);
    logic [63:0] good;
    good = ideal(tv_a[i], tv_b[i], tv_op[i]);
    return faulty_alu(tv_a[i], tv_b[i], tv_op[i], f) == {good == 64'h0, good};
  endfunction

  function automatic int calc_nrun(input int f);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    for (int i = 0; i < NV; i++) begin
      if (!vec_passes(i, f)) return i + 1;
    end
`endif
    return NV;
  endfunction

  logic [64:0] alu_res;
  always_comb alu_res = faulty_alu(alu_if.BusA, alu_if.BusB, alu_if.ALUCtrl, fault_mode);
  assign alu_if.BusW = alu_res[63:0];
  assign alu_if.Zero = alu_res[64];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Run model: phase 0 idle/reset, 1 running, 2 done; k = edges since the Start edge.
  int m_phase = 0;
  int m_k     = 0;
  int m_bus   = -1;
  int m_nrun  = NV;
  int m_fault = 0;

  always @(posedge CLK) begin
    if (Reset) begin
      m_phase <= 0;
      m_k     <= 0;
      m_bus   <= -1;
    end else if (m_phase != 1 && Start) begin
      m_phase <= 1;
      m_k     <= 0;
      m_nrun  <= calc_nrun(fault_mode);
      m_fault <= fault_mode;
    end else if (m_phase == 1) begin
      m_k <= m_k + 1;
      if (m_k + 1 == 3 * m_nrun) m_phase <= 2;
      if ((m_k + 1) % 3 == 1) m_bus <= (m_k + 1) / 3;
    end
  end

  always @(negedge CLK) begin
    int n, p, fi;
    if (chk_en) begin
      n  = (m_phase == 1) ? m_k / 3 : (m_phase == 2) ? m_nrun : 0;
      p  = 0;
      fi = 255;
      for (int i = 0; i < n; i++) begin
        if (vec_passes(i, m_fault)) p++;
        else if (fi == 255) fi = i;
      end
      check("busy", 64'(Busy), 64'(m_phase == 1));
      check("done", 64'(Done), 64'(m_phase == 2));
      check("allpass", 64'(AllPass), 64'(m_phase == 2 && p == n));
      check("pass_count", 64'(PassCount), 64'(p));
      check("fail_count", 64'(FailCount), 64'(n - p));
      check("fail_index", 64'(FailIndex), 64'(fi));
      check("bus_a", alu_if.BusA, (m_bus < 0) ? 64'h0 : tv_a[m_bus]);
      check("bus_b", alu_if.BusB, (m_bus < 0) ? 64'h0 : tv_b[m_bus]);
      check("alu_ctrl", 64'(alu_if.ALUCtrl), (m_bus < 0) ? 64'h0 : 64'(tv_op[m_bus]));
    end
  end

  // Called at a negedge; Start is sampled at the following edge (cycle 0).
  task automatic run(input int fault, input int ign_at, input int rst_at,
                     output int lat, output bit was_reset);
    fault_mode = fault;
    lat        = -1;
    was_reset  = 1'b0;
    Start      = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("busy_after_start", 64'(Busy), 64'd1);
    for (int c = 1; c <= 400; c++) begin
      Start = (c == ign_at);
      Reset = (c == rst_at);
      @(negedge CLK);
      Start = 1'b0;
      Reset = 1'b0;
      if (c == rst_at) begin
        was_reset = 1'b1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_pass", 64'(PassCount), 64'd0);
        check("rst_fail", 64'(FailCount), 64'd0);
        check("rst_fidx", 64'(FailIndex), 64'hFF);
        check("rst_bus_a", alu_if.BusA, 64'd0);
        check("rst_ctrl", 64'(alu_if.ALUCtrl), 64'd0);
        return;
      end
      if (Done) begin
        lat = c;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: Done not seen within 400 cycles (t=%0t)", $time);
  endtask

  initial begin
    int  lat;
    bit  rs;
    int  f, ign, rst;
    Start = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_allpass", 64'(AllPass), 64'd0);
    check("reset_pass", 64'(PassCount), 64'd0);
    check("reset_fidx", 64'(FailIndex), 64'hFF);
    check("reset_bus_a", alu_if.BusA, 64'd0);

    // Good ALU, with a Start pulse at cycle 10 that must be ignored.
    run(0, 10, 0, lat, rs);
    check("good_latency", 64'(lat), 64'd54);
    check("good_pass", 64'(PassCount), 64'd18);
    check("good_fail", 64'(FailCount), 64'd0);
    check("good_fidx", 64'(FailIndex), 64'hFF);
    check("good_allpass", 64'(AllPass), 64'd1);

    // Restart from DONE gives identical results.
    run(0, 0, 0, lat, rs);
    check("rerun_latency", 64'(lat), 64'd54);
    check("rerun_pass", 64'(PassCount), 64'd18);

    // SUB computes A+B.
    run(1, 0, 0, lat, rs);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    check("sub_latency", 64'(lat), 64'd30);
    check("sub_pass", 64'(PassCount), 64'd9);
    check("sub_fail", 64'(FailCount), 64'd1);
`else
    check("sub_latency", 64'(lat), 64'd54);
    check("sub_pass", 64'(PassCount), 64'd14);
    check("sub_fail", 64'(FailCount), 64'd4);
`endif
    check("sub_fidx", 64'(FailIndex), 64'd9);
    check("sub_allpass", 64'(AllPass), 64'd0);

    // Zero stuck at 0.
    run(2, 0, 0, lat, rs);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    check("zero_latency", 64'(lat), 64'd6);
    check("zero_fail", 64'(FailCount), 64'd1);
`else
    check("zero_latency", 64'(lat), 64'd54);
    check("zero_fail", 64'(FailCount), 64'd4);
`endif
    check("zero_fidx", 64'(FailIndex), 64'd1);

    // Reset at cycle 20 of a run, then a clean full run.
    run(0, 0, 20, lat, rs);
    check("midreset_taken", 64'(rs), 64'd1);
    run(0, 0, 0, lat, rs);
    check("post_reset_latency", 64'(lat), 64'd54);
    check("post_reset_pass", 64'(PassCount), 64'd18);

    // Randomised runs, checked by the per-cycle model.
    for (int r = 0; r < 10; r++) begin
      f   = int'($urandom_range(0, 2));
      ign = int'($urandom_range(1, 60));
      rst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 50)) : 0;
      run(f, ign, rst, lat, rs);
      if (!rs) check("rand_latency", 64'(lat), 64'(3 * calc_nrun(f)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Hardware self-test initiator for the 64-bit LEGv8 ALU: the driving end of the ALU's BusA/BusB/ALUCtrl -> BusW/Zero interface.
- Walks a fixed vector table and drives operands and control into the ALU. After a settle window it compares {Zero, BusW} against the expected 65-bit value and accumulates pass/fail results.
- Sits beside the ALU in the datapath. It is used for power-on check and lab bring-up on the board, where no simulator bench is available.

Parameters:
- NUM_VEC, 18, number of table vectors exercised (1..255).
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled (>=1).

Ports:
- CLK  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- BusA  out  64  ALU operand A (registered)
- BusB  out  64  ALU operand B (registered)
- ALUCtrl  out  4  ALU op (registered): AND 0000, OR 0001, ADD 0010, SUB 0110, PASSB 0111
- BusW  in  64  ALU result
- Zero  in  1  ALU zero flag
- Busy  out  1  run in progress
- Done  out  1  run complete; held until Start or Reset
- AllPass  out  1  Done && FailCount==0
- PassCount  out  8  vectors matched
- FailCount  out  8  vectors mismatched
- FailIndex  out  8  index of first mismatch; 8'hFF if none

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values: state IDLE; BusA=0, BusB=0, ALUCtrl=0, Busy=0, Done=0, AllPass=0, PassCount=0, FailCount=0, FailIndex=8'hFF; vector index=0; settle counter=0.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE/DONE + Start:
  - clear PassCount and FailCount; set FailIndex=FF; clear Done; set index=0.
  - go to DRIVE. Busy=1 from the next cycle.
- DRIVE (1 cycle): register table[index].{A,B,ctrl} onto BusA/BusB/ALUCtrl; load settle counter with SETTLE; go to WAIT.
- WAIT: decrement the counter each cycle; go to CHECK when it reaches 0. Duration is exactly SETTLE cycles.
- CHECK (1 cycle): compare {Zero, BusW} with table[index].exp (65 bits).
  - Match: PassCount+1.
  - Mismatch: FailCount+1; if FailIndex==FF, FailIndex=index.
  - If index==NUM_VEC-1, go to DONE; otherwise index+1 and go to DRIVE.
- DONE: Busy=0, Done=1. BusA/BusB/ALUCtrl hold the last vector.
- Latency: Start edge to Done=1 is NUM_VEC*(SETTLE+2) cycles (54 at defaults).
- Start while Busy is ignored.
- Reset while Busy (synchronous) overrides everything: all reset values take effect at that edge and any partial counts are discarded.
- Counters are 8 bits wide and never wrap, because NUM_VEC<=255.
- Expected values use 64-bit two's complement with wrap-around. ADD/SUB carry-out is not checked.
- Zero is part of the comparison; expected Zero=1 exactly when the expected BusW==0.

Optional Feature:
- Macro: ALU_BIST_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK goes directly to DONE regardless of index, so PassCount = FailIndex and FailCount = 1.
- Undefined: all NUM_VEC vectors always run.

Decomposition:
- Package alu_bist_pkg holds:
  - ALUCtrl opcode constants (AND/OR/ADD/SUB/PASSB);
  - the FSM state encoding;
  - the vector record typedef {A[63:0], B[63:0], ctrl[3:0], exp[64:0]};
  - the 18-entry default table.
- Default table, in index order:
  - 0-2 AND: (27,987), (FFFF,0), (FF0A,FFFF)
  - 3-5 OR: (FFFF,1234), (12,1200), (1,F000)
  - 6-8 ADD: (27,987), (FF00,FF), (0,0)
  - 9-11 SUB: (432,432), (FF00,FF), (5,4)
  - 12-14 PASSB: (4312,69), (546,0), (8098,1234)
  - 15 ADD (-19,4); 16 ADD (-3,-5); 17 SUB (-3,-5)
- Sub-module alu_bist_rom: combinational index -> vector record lookup, so the table can be swapped without touching the FSM.

Test Plan:
- Reset, then a Start pulse with a correct behavioural ALU attached -> Busy=1 next cycle; Done=1 exactly 54 cycles after the Start edge; PassCount=18, FailCount=0, FailIndex=FF, AllPass=1.
- Faulty ALU where SUB computes A+B -> vectors 9,10,11,17 fail (vector 9 returns 0x864 with Zero=0); PassCount=14, FailCount=4, FailIndex=9, AllPass=0.
- Zero input stuck at 0 -> vectors 1,8,9,13 fail; FailCount=4, FailIndex=1.
- Reset asserted for one cycle at cycle 20 of a run -> at the next edge Busy=0, all counts 0, BusA/BusB/ALUCtrl=0; a later Start completes a full 54-cycle run with PassCount=18.
- Start pulsed at cycle 10 while Busy -> no effect, and Done still arrives at cycle 54. Start pulsed in DONE -> counts clear and a new run completes with identical results.
- With ALU_BIST_STOP_ON_FAIL_EN defined and the faulty SUB -> Done after vector 9's CHECK (cycle 30); PassCount=9, FailCount=1, FailIndex=9.
